// File: rtl/ysyx_23060075_dmem_resp_if.sv
// Request/response bundle between the memory unit (master) and the data-memory responder (slave).
interface ysyx_23060075_dmem_resp_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] mem_2_addr;
   logic [31:0] mem_2_w;
   logic [3:0]  mem_2_mask;
   logic        mem_2_r_en;
   logic        mem_2_w_en;
   logic [31:0] mem_2_r;
   logic        rsp_valid;
   logic        rsp_err;
   logic        rsp_ready;

   modport master (
      output req_valid, mem_2_addr, mem_2_w, mem_2_mask, mem_2_r_en, mem_2_w_en, rsp_ready,
      input  req_ready, mem_2_r, rsp_valid, rsp_err
   );

   modport slave (
      input  req_valid, mem_2_addr, mem_2_w, mem_2_mask, mem_2_r_en, mem_2_w_en, rsp_ready,
      output req_ready, mem_2_r, rsp_valid, rsp_err
   );
endinterface

// File: rtl/ysyx_23060075_dmem_resp.sv
// Data-memory responder: one outstanding word access, fixed latency, valid/ready response.
module ysyx_23060075_dmem_resp #(
   parameter int unsigned DEPTH_LOG2 = 12,
   parameter int unsigned LATENCY    = 2,
   parameter logic [31:0] BASE_ADDR  = 32'h8000_0000
) (
   input logic                       clk,
   input logic                       rst,
   ysyx_23060075_dmem_resp_if.slave  mem_if
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam int unsigned CNT_W = 4;
   localparam logic [32:0] BASE_EXT  = {1'b0, BASE_ADDR};
   localparam logic [32:0] LIMIT_EXT = BASE_EXT + (33'(1) << (DEPTH_LOG2 + 2));

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  mask;
      logic        r_en;
      logic        w_en;
   } req_t;

   logic [31:0]     mem_q [DEPTH];

   state_e          state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   req_t            req_q, req_d;
   logic            req_ready_q, req_ready_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic            rsp_err_q, rsp_err_d;
   logic [31:0]     rdata_q, rdata_d;

   logic [32:0]           addr_ext;
   logic [31:0]           offset;
   logic [DEPTH_LOG2-1:0] word_idx;
   logic                  in_range;
   logic                  commit;
   logic                  wr_commit;
   logic                  rd_ok;
   logic                  acc_err;

   // Decode the latched request: range (33-bit, no wrap), word index and access class.
   always_comb begin
      addr_ext  = {1'b0, req_q.addr[31:2], 2'b00};
      offset    = req_q.addr - BASE_ADDR;
      word_idx  = DEPTH_LOG2'(offset >> 2);
      in_range  = (addr_ext >= BASE_EXT) && (addr_ext < LIMIT_EXT);
      commit    = (state_q == WAIT) && (cnt_q == '0);
      rd_ok     = req_q.r_en && !req_q.w_en && in_range;
      wr_commit = commit && req_q.w_en && !req_q.r_en && in_range;
      acc_err   = (req_q.r_en || req_q.w_en) && (!in_range || (req_q.r_en && req_q.w_en));
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         req_q       <= '0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         req_q       <= req_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rdata_q     <= rdata_d;
      end
   end

   // Next state: accept, count down the latency, hold the response until taken.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      unique case (state_q)
         IDLE: begin
            if (mem_if.req_valid && req_ready_q) begin
               req_d.addr  = mem_if.mem_2_addr;
               req_d.wdata = mem_if.mem_2_w;
               req_d.mask  = mem_if.mem_2_mask;
               req_d.r_en  = mem_if.mem_2_r_en;
               req_d.w_en  = mem_if.mem_2_w_en;
               cnt_d       = CNT_W'(LATENCY - 1);
               state_d     = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == '0) state_d = RESP;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         RESP: begin
            if (mem_if.rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Output next values: response captured on the commit edge and frozen while stalled.
   always_comb begin
      req_ready_d = (state_d == IDLE);
      rsp_valid_d = (state_d == RESP);
      rsp_err_d   = 1'b0;
      rdata_d     = '0;
      if (commit) begin
         rsp_err_d = acc_err;
         rdata_d   = rd_ok ? mem_q[word_idx] : '0;
      end else if ((state_q == RESP) && (state_d == RESP)) begin
         rsp_err_d = rsp_err_q;
         rdata_d   = rdata_q;
      end
   end

   // Byte-masked array write; the array itself is never reset.
   always_ff @(posedge clk) begin
      if (!rst && wr_commit) begin
         for (int i = 0; i < 4; i++) begin
            if (req_q.mask[i]) mem_q[word_idx][8*i +: 8] <= req_q.wdata[8*i +: 8];
         end
      end
   end

   assign mem_if.req_ready = req_ready_q;
   assign mem_if.rsp_valid = rsp_valid_q;
   assign mem_if.rsp_err   = rsp_err_q;
   assign mem_if.mem_2_r   = rdata_q;

endmodule

// File: tb/tb_ysyx_23060075_dmem_resp.sv
// Scoreboard bench for the data-memory responder, plus latency-sweep instances.
module tb_ysyx_23060075_dmem_resp;

   localparam int unsigned DL2  = 12;
   localparam int unsigned LAT  = 2;
   localparam logic [31:0] BASE = 32'h8000_0000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rst_sw = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_pass = 0;
   int n_total = 0;
   int bp_mode = 1;
   int sw_done_cnt = 0;

   typedef struct {
      logic        err;
      logic [31:0] data;
      bit          dc;
      int          acc;
   } exp_t;
   exp_t exp_q[$];

   logic [31:0] mdl [int];

   ysyx_23060075_dmem_resp_if bus ();

   ysyx_23060075_dmem_resp #(.DEPTH_LOG2(DL2), .LATENCY(LAT), .BASE_ADDR(BASE)) dut (
      .clk(clk), .rst(rst), .mem_if(bus)
   );

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
   endfunction

   function automatic void fail(string nm);
      n_total++;
      $display("FAIL %s: timed out (cycle %0d)", nm, cyc);
   endfunction

   // Reference: plain word-addressed memory with the access rules applied directly.
   function automatic void model(input logic [31:0] a, input logic [31:0] w, input logic [3:0] m,
                                 input logic r, input logic we,
                                 output logic err, output logic [31:0] d, output bit dc);
      longint unsigned wa, lo, hi;
      int idx;
      logic [31:0] old;
      wa  = {32'd0, a[31:2], 2'b00};
      lo  = {32'd0, BASE};
      hi  = lo + 4 * (64'd1 << DL2);
      idx = int'((wa - lo) >> 2);
      err = 1'b0; d = 32'd0; dc = 1'b0;
      if (r && we) err = 1'b1;
      else if (!r && !we) err = 1'b0;
      else if (wa < lo || wa >= hi) err = 1'b1;
      else if (we) begin
         old = mdl.exists(idx) ? mdl[idx] : 32'd0;
         for (int i = 0; i < 4; i++) if (m[i]) old[8*i +: 8] = w[8*i +: 8];
         mdl[idx] = old;
      end else begin
         if (mdl.exists(idx)) d = mdl[idx];
         else dc = 1'b1;
      end
   endfunction

   // mode 0: expect model result; 1: expect given constants; 2: no response expected (aborted)
   task automatic issue(input logic [31:0] a, input logic [31:0] w, input logic [3:0] m,
                        input logic r, input logic we, input int mode,
                        input logic e_err, input logic [31:0] e_dat);
      int n;
      exp_t e;
      bus.req_valid  = 1'b1;
      bus.mem_2_addr = a;
      bus.mem_2_w    = w;
      bus.mem_2_mask = m;
      bus.mem_2_r_en = r;
      bus.mem_2_w_en = we;
      n = 0;
      @(negedge clk);
      while (!bus.req_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!bus.req_ready) begin
         fail("req_accept");
         bus.req_valid = 1'b0;
         return;
      end
      if (mode != 2) begin
         model(a, w, m, r, we, e.err, e.data, e.dc);
         if (mode == 1) begin
            e.err = e_err; e.data = e_dat; e.dc = 1'b0;
         end
         e.acc = cyc + 1;
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      bus.req_valid  = 1'b0;
      bus.mem_2_addr = $urandom;
      bus.mem_2_w    = $urandom;
      bus.mem_2_mask = 4'($urandom);
      bus.mem_2_r_en = 1'($urandom);
      bus.mem_2_w_en = 1'($urandom);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         fail("drain");
         exp_q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   // Response-side consumer: 0 = stall, 1 = always ready, 2 = random.
   initial begin
      bus.rsp_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (bp_mode)
            0:       bus.rsp_ready = 1'b0;
            1:       bus.rsp_ready = 1'b1;
            default: bus.rsp_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: latency, stability while stalled, and scoreboard compare on handshake.
   bit          prev_v = 1'b0;
   bit          prev_hs = 1'b0;
   logic [31:0] prev_d;
   logic        prev_e;
   always @(negedge clk) begin
      if (rst) begin
         prev_v  = 1'b0;
         prev_hs = 1'b0;
      end else begin
         if (bus.rsp_valid) begin
            if (!prev_v) begin
               if (exp_q.size() == 0) fail("unexpected_rsp");
               else chk("rsp_latency", 32'(cyc - exp_q[0].acc), LAT);
            end else if (!prev_hs) begin
               chk("stall_data_stable", bus.mem_2_r, prev_d);
               chk("stall_err_stable", 32'(bus.rsp_err), 32'(prev_e));
            end
            chk("req_ready_low_in_resp", 32'(bus.req_ready), 32'd0);
            if (bus.rsp_ready && exp_q.size() != 0) begin
               exp_t e;
               e = exp_q.pop_front();
               chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
               if (!e.dc) chk("rsp_data", bus.mem_2_r, e.data);
            end
         end else if (prev_v && !prev_hs) begin
            fail("rsp_valid_dropped_without_handshake");
         end
         prev_v  = bus.rsp_valid;
         prev_hs = bus.rsp_valid && bus.rsp_ready;
         prev_d  = bus.mem_2_r;
         prev_e  = bus.rsp_err;
      end
   end

   // Latency sweep: back-to-back writes with rsp_ready held high.
   genvar g;
   for (g = 0; g < 2; g++) begin : g_sw
      localparam int unsigned SL = (g == 0) ? 1 : 15;
      ysyx_23060075_dmem_resp_if sif ();
      ysyx_23060075_dmem_resp #(.DEPTH_LOG2(DL2), .LATENCY(SL), .BASE_ADDR(BASE)) u_dut (
         .clk(clk), .rst(rst_sw), .mem_if(sif)
      );
      initial begin
         int acc_q[$];
         int n, n_rsp, last_acc;
         bit pv;
         sif.req_valid  = 1'b0;
         sif.mem_2_addr = BASE + 32'(4 * g);
         sif.mem_2_w    = 32'hA5A5_0000 + 32'(g);
         sif.mem_2_mask = 4'hF;
         sif.mem_2_r_en = 1'b0;
         sif.mem_2_w_en = 1'b1;
         sif.rsp_ready  = 1'b1;
         @(negedge clk);
         while (rst_sw) @(negedge clk);
         @(posedge clk);
         #1;
         sif.req_valid = 1'b1;
         n = 0; n_rsp = 0; last_acc = -1; pv = 1'b0;
         while (n_rsp < 4 && n < 300) begin
            @(negedge clk);
            n++;
            if (sif.req_valid && sif.req_ready) begin
               // accept-to-accept: L cycles of wait, one response cycle, one idle cycle
               if (last_acc >= 0) chk($sformatf("sweep%0d_accept_period", SL), 32'(cyc + 1 - last_acc), SL + 2);
               last_acc = cyc + 1;
               acc_q.push_back(cyc + 1);
            end
            if (sif.rsp_valid && !pv) begin
               if (acc_q.size() == 0) fail($sformatf("sweep%0d_unexpected_rsp", SL));
               else chk($sformatf("sweep%0d_latency", SL), 32'(cyc - acc_q.pop_front()), SL);
               chk($sformatf("sweep%0d_err", SL), 32'(sif.rsp_err), 32'd0);
               chk($sformatf("sweep%0d_wdata_zero", SL), sif.mem_2_r, 32'd0);
               n_rsp++;
            end
            pv = sif.rsp_valid;
         end
         if (n_rsp < 4) fail($sformatf("sweep%0d_responses", SL));
         sif.req_valid = 1'b0;
         sw_done_cnt++;
      end
   end

   initial begin
      int n;
      logic [31:0] a;
      logic r, we;
      int k, e;
      bus.req_valid  = 1'b0;
      bus.mem_2_addr = '0;
      bus.mem_2_w    = '0;
      bus.mem_2_mask = '0;
      bus.mem_2_r_en = 1'b0;
      bus.mem_2_w_en = 1'b0;

      // Reset values while rst is high, then ready one edge after release.
      repeat (3) begin
         @(negedge clk);
         chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
         chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
         chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
         chk("rst_rdata", bus.mem_2_r, 32'd0);
      end
      @(posedge clk); #1;
      rst = 1'b0; rst_sw = 1'b0;
      @(posedge clk); #1;
      chk("req_ready_after_rst", 32'(bus.req_ready), 32'd1);

      // Full-word write then read.
      issue(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b1, 0, 1'b0, 32'd0);
      issue(32'h8000_0010, 32'h0, 4'h0, 1'b1, 1'b0, 1, 1'b0, 32'hDEAD_BEEF);
      drain();

      // Masked byte writes.
      issue(32'h8000_0010, 32'h1122_3344, 4'hF, 1'b0, 1'b1, 0, 1'b0, 32'd0);
      issue(32'h8000_0011, 32'h0000_AA00, 4'h2, 1'b0, 1'b1, 0, 1'b0, 32'd0);
      issue(32'h8000_0010, 32'hBB00_0000, 4'h8, 1'b0, 1'b1, 0, 1'b0, 32'd0);
      issue(32'h8000_0010, 32'h0, 4'hF, 1'b1, 1'b0, 1, 1'b0, 32'hBB22_AA44);
      issue(32'h8000_0010, 32'h5A5A_5A5A, 4'h0, 1'b0, 1'b1, 1, 1'b0, 32'd0);

      // Error cases; the both-enables request must leave the word untouched.
      issue(32'h7FFF_FFFC, 32'h0, 4'hF, 1'b1, 1'b0, 1, 1'b1, 32'd0);
      issue(BASE + 32'h4000, 32'h0, 4'hF, 1'b1, 1'b0, 1, 1'b1, 32'd0);
      issue(32'h8000_0010, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b1, 1, 1'b1, 32'd0);
      issue(32'h8000_0010, 32'h0, 4'h0, 1'b1, 1'b0, 1, 1'b0, 32'hBB22_AA44);
      issue(32'h8000_0010, 32'h0, 4'hF, 1'b0, 1'b0, 1, 1'b0, 32'd0);
      drain();

      // Response backpressure for 5 cycles.
      @(negedge clk); bp_mode = 0;
      @(posedge clk); #1;
      issue(32'h8000_0010, 32'h0, 4'hF, 1'b1, 1'b0, 1, 1'b0, 32'hBB22_AA44);
      n = 0;
      while (!bus.rsp_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!bus.rsp_valid) fail("bp_rsp_valid");
      repeat (5) begin
         @(negedge clk);
         chk("bp_rsp_valid_held", 32'(bus.rsp_valid), 32'd1);
         chk("bp_req_ready_low", 32'(bus.req_ready), 32'd0);
         chk("bp_data_held", bus.mem_2_r, 32'hBB22_AA44);
      end
      bp_mode = 1;
      @(negedge clk);
      @(negedge clk);
      chk("bp_req_ready_after_hs", 32'(bus.req_ready), 32'd1);
      chk("bp_rsp_valid_after_hs", 32'(bus.rsp_valid), 32'd0);
      chk("bp_rdata_after_hs", bus.mem_2_r, 32'd0);
      drain();

      // Reset during WAIT aborts the write.
      issue(32'h8000_0020, 32'h5555_5555, 4'hF, 1'b0, 1'b1, 0, 1'b0, 32'd0);
      drain();
      issue(32'h8000_0020, 32'h1234_5678, 4'hF, 1'b0, 1'b1, 2, 1'b0, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_req_ready", 32'(bus.req_ready), 32'd0);
      chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("midrst_rsp_err", 32'(bus.rsp_err), 32'd0);
      chk("midrst_rdata", bus.mem_2_r, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("midrst_req_ready_after", 32'(bus.req_ready), 32'd1);
      chk("midrst_rsp_valid_after", 32'(bus.rsp_valid), 32'd0);
      issue(32'h8000_0020, 32'h0, 4'hF, 1'b1, 1'b0, 1, 1'b0, 32'h5555_5555);
      drain();

      // Randomised traffic against the reference model.
      for (int i = 0; i < 9; i++) issue(BASE + 32'(4 * i), $urandom, 4'hF, 1'b0, 1'b1, 0, 1'b0, 32'd0);
      @(negedge clk); bp_mode = 2;
      @(posedge clk); #1;
      for (int i = 0; i < 80; i++) begin
         k = $urandom_range(0, 9);
         if (k < 8)       a = BASE + 32'($urandom_range(0, 8) << 2) + 32'($urandom_range(0, 3));
         else if (k == 8) a = BASE - 32'(4 * $urandom_range(1, 4));
         else             a = BASE + 32'h4000 + 32'($urandom_range(0, 3) << 2);
         e = $urandom_range(0, 9);
         r  = (e >= 4 && e <= 8);
         we = (e <= 3) || (e == 8);
         issue(a, $urandom, 4'($urandom_range(0, 15)), r, we, 0, 1'b0, 32'd0);
      end
      drain();

      n = 0;
      while (sw_done_cnt < 2 && n < 2000) begin
         @(posedge clk);
         n++;
      end
      if (sw_done_cnt < 2) fail("sweep_done");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
